// File: rtl/logic_table_sweeper.sv
// Programmable N-input truth-table unit: 1-cycle registered eval, or a sweep streaming every row.
// Rows stall on out_ready low with idx/value held; table frozen while sweeping.
module logic_table_sweeper #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tbl_we,
  input  logic [2**N-1:0] tbl_in,
  input  logic           eval_req,
  input  logic [N-1:0]   x_in,
  output logic           eval_valid,
  output logic           eval_out,
  input  logic           start,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_idx,
  output logic           out_val,
  output logic           done,
  output logic [N:0]     ones_count
);

  localparam int W = 2**N;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   tbl;
  logic [N-1:0]   idx;
  logic [N:0]     cnt;
  logic           row_val;
  logic           accept;
  logic           last_row;
  logic [N:0]     cnt_inc;

  assign row_val  = tbl[idx];
  assign accept   = (state == SWEEP) && out_ready;
  assign last_row = (idx == {N{1'b1}});
  assign cnt_inc  = cnt + {{N{1'b0}}, row_val};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SWEEP;
      SWEEP:   if (out_ready && last_row) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl        <= '0;
      idx        <= '0;
      cnt        <= '0;
      ones_count <= '0;
      eval_valid <= 1'b0;
      eval_out   <= 1'b0;
    end else begin
      eval_valid <= eval_req;
      // Reads the pre-write table when a load lands on the same edge.
      if (eval_req) eval_out <= tbl[x_in];
      if (tbl_we && state != SWEEP) tbl <= tbl_in;
      if (state == IDLE && start) begin
        idx <= '0;
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt_inc;
        if (last_row) ones_count <= cnt_inc;
        else          idx        <= idx + N'(1);
      end
    end
  end

  // Row outputs are decoded from registers only, so no input reaches them combinationally.
  assign busy      = (state == SWEEP);
  assign out_valid = (state == SWEEP);
  assign out_idx   = (state == SWEEP) ? idx : '0;
  assign out_val   = (state == SWEEP) && row_val;
  assign done      = (state == DONE);

endmodule
